alu_issue_wb: RTL

Execute-stage wrapper around the ALU. It accepts one decoded data-processing instruction per cycle, reads operands from a 16×32 register file, and presents `src1`, `src2`, `ctrl_cmd` and `current_flags` to the ALU from a registered EX stage. It evaluates the ARM condition field and writes the ALU result and NZCV flags back at the end of the EX cycle. Decode sits upstream; the combinational ALU sits alongside the EX register.

---
 rtl/alu_issue_wb.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_wb.sv
`timescale 1ns/1ps
// alu_issue_wb: execute-stage wrapper around a combinational ALU.
// Accepts one decoded data-processing instruction per cycle, reads operands
// from a 16x32 register file (with r15 reading as pc+8 and forwarding from EX),
// holds them in a registered EX stage that drives the ALU, evaluates the ARM
// condition field against NZCV and writes the result/flags back at the end of
// the EX cycle.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready, hold    issue handshake; hold freezes EX, regfile, flags
//   in_cond .. in_pc           decoded instruction fields
//   alu_src1/src2/ctrl_cmd     operands and command to the ALU (from EX register)
//   alu_flags                  current NZCV to the ALU
//   alu_result, alu_new_flags  ALU outputs
//   flags                      architectural NZCV
//   retire_valid, retire_exec  one-cycle retire pulse and its condition result
//   dbg_addr, dbg_data         combinational register-file read port
module alu_issue_wb #(
  parameter int unsigned NREGS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        hold,
  input  logic [3:0]  in_cond,
  input  logic [7:0]  in_ctrl_cmd,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rm,
  input  logic [3:0]  in_rd,
  input  logic [31:0] in_imm,
  input  logic        in_use_imm,
  input  logic        in_wr_en,
  input  logic        in_set_flags,
  input  logic [31:0] in_pc,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [7:0]  alu_ctrl_cmd,
  output logic [3:0]  alu_flags,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_new_flags,
  output logic [3:0]  flags,
  output logic        retire_valid,
  output logic        retire_exec,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  logic [31:0] regs_q [NREGS];
  logic [3:0]  flags_q;

  logic        ex_valid_q;
  logic [31:0] ex_src1_q, ex_src2_q;
  logic [7:0]  ex_ctrl_cmd_q;
  logic [3:0]  ex_cond_q, ex_rd_q;
  logic        ex_wr_en_q, ex_set_flags_q;

  logic        retire_valid_q, retire_exec_q;

  logic        accept, cond_pass, wb_en, fwd_ok;
  logic [31:0] rn_val, rm_val;
  logic        n_f, z_f, c_f, v_f;

  assign accept = in_valid & ~hold;
  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (ex_cond_q)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = ~z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = ~c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = ~n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = ~v_f;
      4'b1000: cond_pass = c_f & ~z_f;
      4'b1001: cond_pass = ~c_f | z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = ~z_f & (n_f == v_f);
      4'b1101: cond_pass = z_f | (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign wb_en  = ex_valid_q & ~hold & cond_pass;
  // The EX instruction's result is what the file will hold after this edge.
  assign fwd_ok = ex_valid_q & ex_wr_en_q & cond_pass & (ex_rd_q != 4'd15);

  always_comb begin
    rn_val = regs_q[in_rn];
    if (in_rn == 4'd15) begin
      rn_val = in_pc + 32'd8;
    end else if (fwd_ok && (in_rn == ex_rd_q)) begin
      rn_val = alu_result;
    end
  end

  always_comb begin
    rm_val = regs_q[in_rm];
    if (in_rm == 4'd15) begin
      rm_val = in_pc + 32'd8;
    end else if (fwd_ok && (in_rm == ex_rd_q)) begin
      rm_val = alu_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 32'd0;
      end
      flags_q        <= 4'd0;
      ex_valid_q     <= 1'b0;
      ex_src1_q      <= 32'd0;
      ex_src2_q      <= 32'd0;
      ex_ctrl_cmd_q  <= 8'd0;
      ex_cond_q      <= 4'd0;
      ex_rd_q        <= 4'd0;
      ex_wr_en_q     <= 1'b0;
      ex_set_flags_q <= 1'b0;
      retire_valid_q <= 1'b0;
      retire_exec_q  <= 1'b0;
    end else begin
      if (wb_en && ex_wr_en_q && (ex_rd_q != 4'd15)) begin
        regs_q[ex_rd_q] <= alu_result;
      end
      if (wb_en && ex_set_flags_q) begin
        flags_q <= alu_new_flags;
      end
      if (accept) begin
        ex_valid_q     <= 1'b1;
        ex_src1_q      <= rn_val;
        ex_src2_q      <= in_use_imm ? in_imm : rm_val;
        ex_ctrl_cmd_q  <= in_ctrl_cmd;
        ex_cond_q      <= in_cond;
        ex_rd_q        <= in_rd;
        ex_wr_en_q     <= in_wr_en;
        ex_set_flags_q <= in_set_flags;
      end else if (!hold) begin
        ex_valid_q <= 1'b0;
      end
      retire_valid_q <= ex_valid_q & ~hold;
      retire_exec_q  <= ex_valid_q & ~hold & cond_pass;
    end
  end

  assign in_ready     = ~hold;
  assign alu_src1     = ex_src1_q;
  assign alu_src2     = ex_src2_q;
  assign alu_ctrl_cmd = ex_ctrl_cmd_q;
  assign alu_flags    = flags_q;
  assign flags        = flags_q;
  assign retire_valid = retire_valid_q;
  assign retire_exec  = retire_exec_q;
  assign dbg_data     = regs_q[dbg_addr];

endmodule
